axil_regfile: RTL

- Parametrised AXI-Lite slave register file. It is the next generation of the team's simplified AXI-Lite bus.
- Terminates all five channels with the same signal names as the bus interface, minus the prefix.
- Generalised in data width, register count and per-register read-only mode.
- Adds independent AW/W acceptance, byte strobes, SLVERR decoding and hardware-facing register outputs.
- Sits between the bus master and block-level control/status logic.

---
 rtl/axil_pkg.sv | 34 +++
 rtl/axil_hold_slot.sv | 34 +++
 rtl/axil_regfile.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-Lite register file: response codes,
// byte-strobe merge and address-to-register-index decode.
package axil_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_e;

  // Works on the widest supported word; callers zero-extend and truncate.
  function automatic logic [MAX_DATA_W-1:0] strb_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BYTES-1:0]  strb
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (strb[k]) res[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return res;
  endfunction

  function automatic logic [63:0] addr2idx(
    input logic [63:0] addr,
    input int unsigned off_w
  );
    return addr >> off_w;
  endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// One-entry holding register with load/clear and a full flag; used to park an
// accepted AW or W beat until both halves of a write are present.
module axil_hold_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_full
);

  logic         r_full;
  logic [W-1:0] r_q;

  // Load only happens while empty and clear only while full, so they never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_q    <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_q    <= i_d;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_full = r_full;

endmodule

// File: rtl/axil_regfile.sv
// AXI-Lite slave register file: byte-strobed RW registers, hardware-fed RO
// registers, SLVERR on out-of-range or RO writes, per-register write pulses.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic [NUM_REGS*DATA_W-1:0] ro_val_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  logic                    w_aw_full;
  logic                    w_w_full;
  logic [ADDR_W-1:0]       w_awaddr;
  logic [DATA_W+BYTES-1:0] w_w_q;
  logic [DATA_W-1:0]       w_wdata;
  logic [BYTES-1:0]        w_wstrb;
  logic                    w_commit;
  logic [63:0]             w_aw_idx;
  logic [63:0]             w_ar_idx;
  logic [NUM_REGS-1:0]     w_aw_sel;
  logic [NUM_REGS-1:0]     w_ar_sel;
  logic                    w_wr_ok;
  logic                    w_ar_ok;
  logic [DATA_W-1:0]       w_rd_data;
  logic [DATA_W-1:0]       w_reg_q  [NUM_REGS];
  logic [DATA_W-1:0]       w_rd_src [NUM_REGS];

  logic                    r_bvalid;
  axil_resp_e              r_bresp;
  logic                    r_rvalid;
  axil_resp_e              r_rresp;
  logic [DATA_W-1:0]       r_rdata;
  logic [NUM_REGS-1:0]     r_wr_pulse;

  // A full B slot that is being drained this edge does not block the next commit.
  assign w_commit = w_aw_full & w_w_full & (~r_bvalid | bready);

  axil_hold_slot #(.W(ADDR_W)) u_aw_slot (
    .clk    (clk),
    .rst    (rst),
    .i_load (awvalid & ~w_aw_full),
    .i_clr  (w_commit),
    .i_d    (awaddr),
    .o_q    (w_awaddr),
    .o_full (w_aw_full)
  );

  axil_hold_slot #(.W(DATA_W + BYTES)) u_w_slot (
    .clk    (clk),
    .rst    (rst),
    .i_load (wvalid & ~w_w_full),
    .i_clr  (w_commit),
    .i_d    ({wstrb, wdata}),
    .o_q    (w_w_q),
    .o_full (w_w_full)
  );

  assign w_wdata  = w_w_q[DATA_W-1:0];
  assign w_wstrb  = w_w_q[DATA_W +: BYTES];
  assign w_aw_idx = addr2idx(64'(w_awaddr), OFF_W);
  assign w_ar_idx = addr2idx(64'(araddr), OFF_W);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    assign w_aw_sel[gi] = (w_aw_idx == 64'(gi));
    assign w_ar_sel[gi] = (w_ar_idx == 64'(gi));

    if (RO_MASK[gi]) begin : g_ro
      assign w_reg_q[gi]  = '0;
      assign w_rd_src[gi] = ro_val_i[gi*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_commit && w_aw_sel[gi]) begin
          r_q <= DATA_W'(strb_merge(64'(r_q), 64'(w_wdata), MAX_BYTES'(w_wstrb)));
        end
      end
      assign w_reg_q[gi]  = r_q;
      assign w_rd_src[gi] = r_q;
    end

    assign regs_o[gi*DATA_W +: DATA_W] = w_reg_q[gi];
  end

  assign w_wr_ok = |(w_aw_sel & ~RO_MASK);
  assign w_ar_ok = |w_ar_sel;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_sel[i]) w_rd_data = w_rd_src[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_commit ? (w_aw_sel & ~RO_MASK) : '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? OKAY : SLVERR;
      end else if (bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register reads sample pre-commit contents, so a same-edge write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_ar_ok ? OKAY : SLVERR;
    end else if (rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign awready    = ~w_aw_full;
  assign wready     = ~w_w_full;
  assign bvalid     = r_bvalid;
  assign bresp      = r_bresp;
  assign arready    = ~r_rvalid;
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign rresp      = r_rresp;
  assign wr_pulse_o = r_wr_pulse;

endmodule
